// File: rtl/id_stage_pipe_if.sv
// Bundle between the decode stage and its neighbours: the IF/ID handshake,
// writeback port, forwarding selects, fetch redirect and the ID/EX payload.
// The stage itself sits on the slave side; the surrounding pipeline (or a
// testbench) drives the master side.
interface id_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_f;
  logic            stall;
  logic            flush;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] alu_out_m;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            ex_ready;
  logic            ex_valid;
  logic [AW-1:0]   ex_rs;
  logic [AW-1:0]   ex_rt;
  logic [AW-1:0]   ex_rd;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_imm;
  logic [9:0]      ex_ctrl;
  logic            ex_illegal;

  modport master (
    output in_valid, instr, pc_plus4, pc_f, stall, flush,
           wb_we, wb_addr, wb_data, alu_out_m, fwd_a, fwd_b, ex_ready,
    input  in_ready, redirect, redirect_pc, ex_valid, ex_rs, ex_rt, ex_rd,
           ex_a, ex_b, ex_imm, ex_ctrl, ex_illegal
  );

  modport slave (
    input  in_valid, instr, pc_plus4, pc_f, stall, flush,
           wb_we, wb_addr, wb_data, alu_out_m, fwd_a, fwd_b, ex_ready,
    output in_ready, redirect, redirect_pc, ex_valid, ex_rs, ex_rt, ex_rd,
           ex_a, ex_b, ex_imm, ex_ctrl, ex_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: write-through register file, operand forwarding mux,
// branch/jump resolution in ID with a fetch redirect, and an elastic
// valid/ready ID/EX register with stall and flush.
// ex_ctrl layout: {link, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, alu_ctrl[3:0]}.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  id_stage_pipe_if.slave pipe_io
);
  localparam int AW = $clog2(NREG);

  // ALU operation codes handed to EX
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  logic [XLEN-1:0] regs_q [NREG];

  logic            ex_valid_q;
  logic [AW-1:0]   ex_rs_q, ex_rt_q, ex_rd_q;
  logic [XLEN-1:0] ex_a_q, ex_b_q, ex_imm_q;
  logic [9:0]      ex_ctrl_q;
  logic            ex_illegal_q;

  logic [5:0]      opcode, funct;
  logic [AW-1:0]   rs_idx, rt_idx;
  logic [XLEN-1:0] imm_ext, rf_a, rf_b, op_a, op_b;
  logic [XLEN-1:0] br_target, j_target, target;
  logic            fire, in_ready;

  logic            rw, m2r, mw, asrc, rdst, link, illegal;
  logic [3:0]      alu;
  logic            is_branch, br_cond, is_jump, is_jr, is_jal;

  logic [AW-1:0]   ex_rd_d;
  logic [XLEN-1:0] ex_imm_d;
  logic [9:0]      ex_ctrl_d;
  logic            xfer_taken;

  assign opcode  = pipe_io.instr[31:26];
  assign funct   = pipe_io.instr[5:0];
  assign rs_idx  = AW'(pipe_io.instr[25:21]);
  assign rt_idx  = AW'(pipe_io.instr[20:16]);
  assign imm_ext = {{(XLEN-16){pipe_io.instr[15]}}, pipe_io.instr[15:0]};

  // Register file reads with same-cycle writeback bypass; r0 is hardwired zero
  always_comb begin
    rf_a = regs_q[rs_idx];
    rf_b = regs_q[rt_idx];
    if (pipe_io.wb_we && (pipe_io.wb_addr == rs_idx)) rf_a = pipe_io.wb_data;
    if (pipe_io.wb_we && (pipe_io.wb_addr == rt_idx)) rf_b = pipe_io.wb_data;
    if (rs_idx == '0) rf_a = '0;
    if (rt_idx == '0) rf_b = '0;
  end

  // Forwarding mux; a zero source register ignores the select entirely
  always_comb begin
    case (pipe_io.fwd_a)
      2'd1:    op_a = pipe_io.alu_out_m;
      2'd2:    op_a = pipe_io.wb_data;
      default: op_a = rf_a;
    endcase
    case (pipe_io.fwd_b)
      2'd1:    op_b = pipe_io.alu_out_m;
      2'd2:    op_b = pipe_io.wb_data;
      default: op_b = rf_b;
    endcase
    if (rs_idx == '0) op_a = '0;
    if (rt_idx == '0) op_b = '0;
  end

  // Instruction decode into control bits and control-transfer class
  always_comb begin
    rw = 1'b0; m2r = 1'b0; mw = 1'b0; asrc = 1'b0; rdst = 1'b0; link = 1'b0;
    alu = ALU_ADD; illegal = 1'b0;
    is_branch = 1'b0; br_cond = 1'b0; is_jump = 1'b0; is_jr = 1'b0; is_jal = 1'b0;
    case (opcode)
      6'h00: begin
        rw = 1'b1; rdst = 1'b1;
        case (funct)
          6'h20, 6'h21: alu = ALU_ADD;
          6'h22, 6'h23: alu = ALU_SUB;
          6'h24: alu = ALU_AND;
          6'h25: alu = ALU_OR;
          6'h26: alu = ALU_XOR;
          6'h27: alu = ALU_NOR;
          6'h2A: alu = ALU_SLT;
          6'h2B: alu = ALU_SLTU;
          6'h00: alu = ALU_SLL;
          6'h02: alu = ALU_SRL;
          6'h03: alu = ALU_SRA;
          6'h08: begin rw = 1'b0; rdst = 1'b0; is_jump = 1'b1; is_jr = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      6'h01: begin
        is_branch = 1'b1;
        case (pipe_io.instr[20:16])
          5'd0:    br_cond = op_a[XLEN-1];
          5'd1:    br_cond = !op_a[XLEN-1];
          default: illegal = 1'b1;
        endcase
      end
      6'h02: is_jump = 1'b1;
      6'h03: begin is_jump = 1'b1; is_jal = 1'b1; link = 1'b1; rw = 1'b1; end
      6'h04: begin is_branch = 1'b1; br_cond = (op_a == op_b); end
      6'h05: begin is_branch = 1'b1; br_cond = (op_a != op_b); end
      6'h06: begin is_branch = 1'b1; br_cond = op_a[XLEN-1] || (op_a == '0); end
      6'h07: begin is_branch = 1'b1; br_cond = !op_a[XLEN-1] && (op_a != '0); end
      6'h08, 6'h09: begin rw = 1'b1; asrc = 1'b1; alu = ALU_ADD;  end
      6'h0A: begin rw = 1'b1; asrc = 1'b1; alu = ALU_SLT;  end
      6'h0B: begin rw = 1'b1; asrc = 1'b1; alu = ALU_SLTU; end
      6'h0C: begin rw = 1'b1; asrc = 1'b1; alu = ALU_AND;  end
      6'h0D: begin rw = 1'b1; asrc = 1'b1; alu = ALU_OR;   end
      6'h0E: begin rw = 1'b1; asrc = 1'b1; alu = ALU_XOR;  end
      6'h0F: begin rw = 1'b1; asrc = 1'b1; alu = ALU_LUI;  end
      6'h23: begin rw = 1'b1; m2r = 1'b1; asrc = 1'b1; end
      6'h2B: begin mw = 1'b1; asrc = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  assign br_target = pipe_io.pc_plus4 + {imm_ext[XLEN-3:0], 2'b00};
  assign j_target  = {pipe_io.pc_plus4[XLEN-1:28], pipe_io.instr[25:0], 2'b00};

  // Pick the control-transfer target and build the payload headed for EX
  always_comb begin
    if (is_jr)        target = op_a;
    else if (is_jump) target = j_target;
    else              target = br_target;
    xfer_taken = !illegal && ((is_branch && br_cond) || is_jump);
    ex_ctrl_d  = illegal ? 10'd0 : {link, rw, m2r, mw, asrc, rdst, alu};
    ex_rd_d    = is_jal ? AW'(NREG-1) : AW'(pipe_io.instr[15:11]);
    ex_imm_d   = is_jal ? pipe_io.pc_plus4 : imm_ext;
  end

  assign in_ready = !pipe_io.stall && (!ex_valid_q || pipe_io.ex_ready);
  assign fire     = pipe_io.in_valid && in_ready;

  assign pipe_io.in_ready    = in_ready;
  assign pipe_io.redirect    = !rst_i && fire && xfer_taken && (target != pipe_io.pc_f);
  assign pipe_io.redirect_pc = target;

  // Register file storage; writes to r0 are dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (pipe_io.wb_we && (pipe_io.wb_addr != '0)) begin
      regs_q[pipe_io.wb_addr] <= pipe_io.wb_data;
    end
  end

  // ID/EX register: flush beats load, load only when EX can take it, else hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
      ex_illegal_q <= 1'b0;
    end else if (pipe_io.flush) begin
      ex_valid_q <= 1'b0;
    end else if (!ex_valid_q || pipe_io.ex_ready) begin
      ex_valid_q <= pipe_io.in_valid && !pipe_io.stall;
      if (pipe_io.in_valid && !pipe_io.stall) begin
        ex_rs_q      <= rs_idx;
        ex_rt_q      <= rt_idx;
        ex_rd_q      <= ex_rd_d;
        ex_a_q       <= op_a;
        ex_b_q       <= op_b;
        ex_imm_q     <= ex_imm_d;
        ex_ctrl_q    <= ex_ctrl_d;
        ex_illegal_q <= illegal;
      end
    end
  end

  assign pipe_io.ex_valid   = ex_valid_q;
  assign pipe_io.ex_rs      = ex_rs_q;
  assign pipe_io.ex_rt      = ex_rt_q;
  assign pipe_io.ex_rd      = ex_rd_q;
  assign pipe_io.ex_a       = ex_a_q;
  assign pipe_io.ex_b       = ex_b_q;
  assign pipe_io.ex_imm     = ex_imm_q;
  assign pipe_io.ex_ctrl    = ex_ctrl_q;
  assign pipe_io.ex_illegal = ex_illegal_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a table of decode vectors with
// hand-computed results, plus short sequences for reset, write-through,
// stall, backpressure hold, flush and r0 behaviour.
module tb_id_stage_pipe;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_stage_pipe_if #(.XLEN(32), .NREG(32)) bus ();

  id_stage_pipe #(.XLEN(32), .NREG(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .pipe_io (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] pc_f;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        exp_redirect;
    logic [31:0] exp_pc;
    logic [9:0]  exp_ctrl;
    logic [4:0]  exp_rd;
    logic [31:0] exp_imm;
    logic        exp_ill;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [20];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.instr    = v.instr;
    bus.pc_plus4 = v.pc_plus4;
    bus.pc_f     = v.pc_f;
    bus.fwd_a    = v.fwd_a;
    bus.fwd_b    = v.fwd_b;
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.wb_we    = 1'b1;
    bus.wb_addr  = addr;
    bus.wb_data  = data;
    @(posedge clk);
    #1;
    bus.wb_we = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h0800_0040;
    bus.pc_plus4  = 32'h100;
    bus.pc_f      = 32'h104;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.wb_we     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = 32'd8;
    bus.alu_out_m = 32'd9;
    bus.fwd_a     = 2'd0;
    bus.fwd_b     = 2'd0;
    bus.ex_ready  = 1'b1;

    vecs[0]  = '{{6'h04,5'd1,5'd2,16'd3},      32'h100, 32'h104, 2'd0, 2'd0, 1'b1, 32'h10C,      10'h000, 5'd0,  32'h3,        1'b0, 32'd7,        32'd7};
    vecs[1]  = '{{6'h05,5'd1,5'd3,16'd3},      32'h100, 32'h104, 2'd1, 2'd0, 1'b0, 32'h0,        10'h000, 5'd0,  32'h3,        1'b0, 32'd9,        32'd9};
    vecs[2]  = '{{6'h05,5'd1,5'd3,16'd3},      32'h100, 32'h104, 2'd2, 2'd0, 1'b1, 32'h10C,      10'h000, 5'd0,  32'h3,        1'b0, 32'd8,        32'd9};
    vecs[3]  = '{{6'h00,5'd1,5'd3,5'd6,5'd0,6'h20}, 32'h100, 32'h104, 2'd0, 2'd0, 1'b0, 32'h0,   10'h110, 5'd6,  32'h3020,     1'b0, 32'd7,        32'd9};
    vecs[4]  = '{{6'h23,5'd1,5'd7,16'hFFFC},   32'h100, 32'h104, 2'd0, 2'd0, 1'b0, 32'h0,        10'h1A0, 5'd31, 32'hFFFFFFFC, 1'b0, 32'd7,        32'd0};
    vecs[5]  = '{{6'h2B,5'd1,5'd3,16'h0010},   32'h100, 32'h104, 2'd0, 2'd0, 1'b0, 32'h0,        10'h060, 5'd0,  32'h10,       1'b0, 32'd7,        32'd9};
    vecs[6]  = '{{6'h06,5'd4,5'd0,16'hFFFF},   32'h100, 32'h104, 2'd0, 2'd0, 1'b1, 32'hFC,       10'h000, 5'd31, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFB, 32'd0};
    vecs[7]  = '{{6'h07,5'd4,5'd0,16'h0004},   32'h100, 32'h104, 2'd0, 2'd0, 1'b0, 32'h0,        10'h000, 5'd0,  32'h4,        1'b0, 32'hFFFFFFFB, 32'd0};
    vecs[8]  = '{{6'h01,5'd4,5'd0,16'h0004},   32'h100, 32'h104, 2'd0, 2'd0, 1'b1, 32'h110,      10'h000, 5'd0,  32'h4,        1'b0, 32'hFFFFFFFB, 32'd0};
    vecs[9]  = '{{6'h01,5'd1,5'd1,16'h0008},   32'h100, 32'h104, 2'd0, 2'd0, 1'b1, 32'h120,      10'h000, 5'd0,  32'h8,        1'b0, 32'd7,        32'd7};
    vecs[10] = '{{6'h00,5'd8,5'd0,5'd0,5'd0,6'h08}, 32'h100, 32'h104, 2'd0, 2'd0, 1'b1, 32'h200, 10'h000, 5'd0,  32'h8,        1'b0, 32'h200,      32'd0};
    vecs[11] = '{{6'h00,5'd8,5'd0,5'd0,5'd0,6'h08}, 32'h100, 32'h200, 2'd0, 2'd0, 1'b0, 32'h0,   10'h000, 5'd0,  32'h8,        1'b0, 32'h200,      32'd0};
    vecs[12] = '{{6'h04,5'd1,5'd2,16'd1},      32'h100, 32'h104, 2'd0, 2'd0, 1'b0, 32'h0,        10'h000, 5'd0,  32'h1,        1'b0, 32'd7,        32'd7};
    vecs[13] = '{{6'h03,26'h0400000},          32'h10000004, 32'h10000000, 2'd0, 2'd0, 1'b1, 32'h11000000, 10'h300, 5'd31, 32'h10000004, 1'b0, 32'd7, 32'd0};
    vecs[14] = '{{6'h02,26'h0000040},          32'h100, 32'h104, 2'd0, 2'd0, 1'b1, 32'h100,      10'h000, 5'd0,  32'h40,       1'b0, 32'd0,        32'd0};
    vecs[15] = '{{6'h3F,5'd1,5'd2,16'd3},      32'h100, 32'h104, 2'd0, 2'd0, 1'b0, 32'h0,        10'h000, 5'd0,  32'h3,        1'b1, 32'd7,        32'd7};
    vecs[16] = '{{6'h00,5'd1,5'd2,5'd3,5'd0,6'h3F}, 32'h100, 32'h104, 2'd0, 2'd0, 1'b0, 32'h0,   10'h000, 5'd3,  32'h183F,     1'b1, 32'd7,        32'd7};
    vecs[17] = '{{6'h00,5'd0,5'd3,5'd6,5'd0,6'h20}, 32'h100, 32'h104, 2'd1, 2'd2, 1'b0, 32'h0,   10'h110, 5'd6,  32'h3020,     1'b0, 32'd0,        32'd8};
    vecs[18] = '{{6'h0D,5'd1,5'd9,16'h8001},   32'h100, 32'h104, 2'd0, 2'd0, 1'b0, 32'h0,        10'h123, 5'd16, 32'hFFFF8001, 1'b0, 32'd7,        32'd0};
    vecs[19] = '{{6'h0F,5'd0,5'd9,16'h1234},   32'h100, 32'h104, 2'd0, 2'd0, 1'b0, 32'h0,        10'h12B, 5'd2,  32'h1234,     1'b0, 32'd0,        32'd0};

    // Reset: redirect suppressed even with a valid jump presented
    #1;
    checkOutput("rst.redirect", 32'(bus.redirect), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.ex_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("rst.ex_ctrl",  32'(bus.ex_ctrl),  32'd0);
    checkOutput("rst.ex_a",     bus.ex_a,          32'd0);
    checkOutput("rst.ex_imm",   bus.ex_imm,        32'd0);
    checkOutput("rst.ex_rd",    32'(bus.ex_rd),    32'd0);

    // Write-through: writeback to r5 read by the same instruction
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr    = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20};
    bus.wb_we    = 1'b1;
    bus.wb_addr  = 5'd5;
    bus.wb_data  = 32'h1234;
    @(posedge clk);
    #1;
    checkOutput("wt.bypass", bus.ex_a, 32'h1234);
    @(negedge clk);
    bus.wb_we   = 1'b0;
    bus.wb_data = 32'd8;
    @(posedge clk);
    #1;
    checkOutput("wt.stored", bus.ex_a, 32'h1234);

    writeReg(5'd1, 32'd7);
    writeReg(5'd2, 32'd7);
    writeReg(5'd3, 32'd9);
    writeReg(5'd4, 32'hFFFFFFFB);
    writeReg(5'd8, 32'h200);
    bus.wb_data = 32'd8;
    checkOutput("idle.ex_valid", 32'(bus.ex_valid), 32'd0);

    // Table-driven decode vectors
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      checkOutput($sformatf("vec%0d.redirect", i), 32'(bus.redirect), 32'(vecs[i].exp_redirect));
      if (vecs[i].exp_redirect)
        checkOutput($sformatf("vec%0d.redirect_pc", i), bus.redirect_pc, vecs[i].exp_pc);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d.ex_valid", i),   32'(bus.ex_valid),   32'd1);
      checkOutput($sformatf("vec%0d.ex_ctrl", i),    32'(bus.ex_ctrl),    32'(vecs[i].exp_ctrl));
      checkOutput($sformatf("vec%0d.ex_rd", i),      32'(bus.ex_rd),      32'(vecs[i].exp_rd));
      checkOutput($sformatf("vec%0d.ex_imm", i),     bus.ex_imm,          vecs[i].exp_imm);
      checkOutput($sformatf("vec%0d.ex_illegal", i), 32'(bus.ex_illegal), 32'(vecs[i].exp_ill));
      checkOutput($sformatf("vec%0d.ex_a", i),       bus.ex_a,            vecs[i].exp_a);
      checkOutput($sformatf("vec%0d.ex_b", i),       bus.ex_b,            vecs[i].exp_b);
    end

    // Stall with EX ready: not accepted, no redirect, bubble inserted
    @(negedge clk);
    applyStimulus(vecs[0]);
    bus.stall = 1'b1;
    #1;
    checkOutput("stall.in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("stall.redirect", 32'(bus.redirect), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("stall.ex_valid", 32'(bus.ex_valid), 32'd0);

    // Backpressure: load an add, then hold it while EX is not ready
    @(negedge clk);
    bus.stall = 1'b0;
    applyStimulus(vecs[3]);
    @(posedge clk);
    #1;
    checkOutput("hold.load_ctrl", 32'(bus.ex_ctrl), 32'h110);
    @(negedge clk);
    bus.ex_ready = 1'b0;
    applyStimulus(vecs[10]);
    #1;
    checkOutput("hold.in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("hold.redirect", 32'(bus.redirect), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold%0d.ex_valid", c), 32'(bus.ex_valid), 32'd1);
      checkOutput($sformatf("hold%0d.ex_ctrl", c),  32'(bus.ex_ctrl),  32'h110);
      checkOutput($sformatf("hold%0d.ex_rd", c),    32'(bus.ex_rd),    32'd6);
      checkOutput($sformatf("hold%0d.ex_a", c),     bus.ex_a,          32'd7);
      checkOutput($sformatf("hold%0d.ex_b", c),     bus.ex_b,          32'd9);
    end

    // Flush together with fire: redirect still driven, instruction discarded
    @(negedge clk);
    bus.ex_ready = 1'b1;
    bus.flush    = 1'b1;
    applyStimulus(vecs[14]);
    #1;
    checkOutput("flush.redirect", 32'(bus.redirect), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("flush.ex_valid", 32'(bus.ex_valid), 32'd0);

    // r0 stays zero: write attempt with bypass, and forwarding selects ignored
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.instr   = {6'h00, 5'd0, 5'd0, 5'd6, 5'd0, 6'h20};
    bus.fwd_a   = 2'd2;
    bus.fwd_b   = 2'd1;
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'hFFFF;
    @(posedge clk);
    #1;
    checkOutput("r0.bypass_a", bus.ex_a, 32'd0);
    checkOutput("r0.bypass_b", bus.ex_b, 32'd0);
    @(negedge clk);
    bus.wb_we = 1'b0;
    bus.fwd_a = 2'd0;
    bus.fwd_b = 2'd0;
    @(posedge clk);
    #1;
    checkOutput("r0.stored", bus.ex_a, 32'd0);
    checkOutput("r0.ex_valid", 32'(bus.ex_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
